// File: rtl/riscv_next_pkg.sv
// Shared types for the next-PC resolve tracker: prediction entry and instruction class.
package riscv_next_pkg;

  localparam int unsigned MaxAddrWidth = 64;

  typedef logic [MaxAddrWidth-1:0] addr_t;

  typedef struct packed {
    addr_t pc;
    logic  pred_taken;
    addr_t pred_addr;
  } pred_entry_t;

  typedef struct packed {
    logic jal;
    logic jalr;
    logic branch;
    logic rs1_ra;
  } insn_class_t;

  function automatic logic is_ctrl(insn_class_t c);
    return c.jal | c.jalr | c.branch;
  endfunction

endpackage

// File: rtl/riscv_next_pred_fifo.sv
// Synchronous FIFO of in-flight predictions with a clear that wins over same-cycle push/pop.
module riscv_next_pred_fifo
  import riscv_next_pkg::*;
#(
  parameter int unsigned Depth = 4
) (
  input  logic        clk_i,
  input  logic        rst_ni,
  input  logic        clr_i,
  input  logic        push_i,
  input  logic        pop_i,
  input  pred_entry_t data_i,
  output pred_entry_t head_o,
  output logic        empty_o,
  output logic        full_o
);

  localparam int unsigned PtrW = (Depth > 1) ? $clog2(Depth) : 1;

  logic [PtrW-1:0] wptr_q, rptr_q;
  logic [PtrW:0]   count_q;
  pred_entry_t     mem_q [Depth];
  logic            push_ok, pop_ok;

  assign empty_o = (count_q == '0);
  assign full_o  = (count_q == (PtrW+1)'(Depth));
  assign pop_ok  = pop_i && !empty_o;
  // A push into a full FIFO is only legal when the head leaves in the same cycle.
  assign push_ok = push_i && (!full_o || pop_ok);
  assign head_o  = mem_q[rptr_q];

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      wptr_q  <= '0;
      rptr_q  <= '0;
      count_q <= '0;
    end else if (clr_i) begin
      wptr_q  <= '0;
      rptr_q  <= '0;
      count_q <= '0;
    end else begin
      if (push_ok) wptr_q <= wptr_q + 1'b1;
      if (pop_ok)  rptr_q <= rptr_q + 1'b1;
      unique case ({push_ok, pop_ok})
        2'b10:   count_q <= count_q + 1'b1;
        2'b01:   count_q <= count_q - 1'b1;
        default: count_q <= count_q;
      endcase
    end
  end

  always_ff @(posedge clk_i) begin
    if (push_ok && !clr_i) mem_q[wptr_q] <= data_i;
  end

endmodule

// File: rtl/riscv_next_resolve_tracker.sv
// Tracks predicted next-PCs until execute resolves them; emits history updates,
// mispredict redirects and hit/miss statistics.
module riscv_next_resolve_tracker
  import riscv_next_pkg::*;
#(
  parameter int unsigned ADDR_WIDTH = 64,
  parameter int unsigned DEPTH      = 4,
  parameter int unsigned CNT_WIDTH  = 32
) (
  input  logic                  clk,
  input  logic                  nreset,
  input  logic                  enable,
  input  logic                  i_stall,
  input  logic                  i_if_fire,
  input  logic [ADDR_WIDTH-1:0] i_if_pc,
  input  logic                  i_pred_taken,
  input  logic [ADDR_WIDTH-1:0] i_pred_addr,
  input  logic                  i_ex_valid,
  input  logic [ADDR_WIDTH-1:0] i_ex_pc,
  input  logic                  i_ex_jal,
  input  logic                  i_ex_jalr,
  input  logic                  i_ex_branch,
  input  logic                  i_ex_rs1_ra,
  input  logic                  i_ex_taken,
  input  logic [ADDR_WIDTH-1:0] i_ex_target,
  input  logic                  i_flush,
  output logic                  o_hist_valid,
  output logic [ADDR_WIDTH-1:0] o_hist_pc,
  output logic [ADDR_WIDTH-1:0] o_hist_jump_addr,
  output logic                  o_hist_jal,
  output logic                  o_hist_jalr,
  output logic                  o_hist_branch,
  output logic                  o_hist_rs1_ra,
  output logic                  o_hist_jump_branch,
  output logic                  o_hist_flush,
  output logic                  o_redirect,
  output logic [ADDR_WIDTH-1:0] o_redirect_addr,
  output logic                  o_full,
  output logic                  o_err,
  output logic [CNT_WIDTH-1:0]  o_hits,
  output logic [CNT_WIDTH-1:0]  o_misses
);

  logic                  active, pop, push, drop, fifo_clr, fifo_full, fifo_empty;
  logic                  head_match, eff_taken, mispredict;
  logic [ADDR_WIDTH-1:0] head_pc, head_addr, eff_addr, pc_plus4;
  pred_entry_t           push_entry, head;
  insn_class_t           ex_cls, hist_cls_q;

  logic                  hist_valid_q, hist_jb_q, hist_flush_q, redirect_q;
  logic [ADDR_WIDTH-1:0] hist_pc_q, hist_addr_q, redirect_addr_q;
  logic                  err_q, err_d;
  logic [CNT_WIDTH-1:0]  hits_q, hits_d, misses_q, misses_d;

  assign active = enable && !i_stall;
  assign pop    = i_ex_valid && active;
  assign push   = i_if_fire && active && !i_flush;
  assign drop   = push && fifo_full && !pop;

  assign ex_cls     = '{jal: i_ex_jal, jalr: i_ex_jalr, branch: i_ex_branch, rs1_ra: i_ex_rs1_ra};
  assign push_entry = '{pc: MaxAddrWidth'(i_if_pc), pred_taken: i_pred_taken,
                        pred_addr: MaxAddrWidth'(i_pred_addr)};

  assign head_pc    = head.pc[ADDR_WIDTH-1:0];
  assign head_addr  = head.pred_addr[ADDR_WIDTH-1:0];
  assign pc_plus4   = i_ex_pc + ADDR_WIDTH'(4);
  // Missing or out-of-order entry: treat as predicted fall-through.
  assign head_match = !fifo_empty && (head_pc == i_ex_pc);
  assign eff_taken  = head_match ? head.pred_taken : 1'b0;
  assign eff_addr   = head_match ? head_addr : pc_plus4;
  assign mispredict = (i_ex_taken != eff_taken) || (i_ex_taken && (i_ex_target != eff_addr));
  assign fifo_clr   = active && (i_flush || (pop && mispredict));

  riscv_next_pred_fifo #(
    .Depth (DEPTH)
  ) u_fifo (
    .clk_i   (clk),
    .rst_ni  (nreset),
    .clr_i   (fifo_clr),
    .push_i  (push),
    .pop_i   (pop),
    .data_i  (push_entry),
    .head_o  (head),
    .empty_o (fifo_empty),
    .full_o  (fifo_full)
  );

  always_comb begin
    err_d    = err_q | drop | (pop && !head_match);
    hits_d   = hits_q;
    misses_d = misses_q;
    if (pop && is_ctrl(ex_cls) && !i_flush) begin
      if (mispredict) begin
        if (misses_q != '1) misses_d = misses_q + CNT_WIDTH'(1);
      end else if (hits_q != '1) begin
        hits_d = hits_q + CNT_WIDTH'(1);
      end
    end
  end

  always_ff @(posedge clk or negedge nreset) begin
    if (!nreset) begin
      hist_valid_q    <= 1'b0;
      hist_pc_q       <= '0;
      hist_addr_q     <= '0;
      hist_cls_q      <= '0;
      hist_jb_q       <= 1'b0;
      hist_flush_q    <= 1'b0;
      redirect_q      <= 1'b0;
      redirect_addr_q <= '0;
      err_q           <= 1'b0;
      hits_q          <= '0;
      misses_q        <= '0;
    end else begin
      hist_valid_q <= pop;
      redirect_q   <= pop && mispredict && !i_flush;
      if (pop) begin
        hist_pc_q       <= i_ex_pc;
        hist_addr_q     <= i_ex_target;
        hist_cls_q      <= ex_cls;
        hist_jb_q       <= i_ex_taken;
        hist_flush_q    <= i_flush;
        redirect_addr_q <= i_ex_taken ? i_ex_target : pc_plus4;
      end
      if (active) begin
        err_q    <= err_d;
        hits_q   <= hits_d;
        misses_q <= misses_d;
      end
    end
  end

  assign o_hist_valid       = hist_valid_q;
  assign o_hist_pc          = hist_pc_q;
  assign o_hist_jump_addr   = hist_addr_q;
  assign o_hist_jal         = hist_cls_q.jal;
  assign o_hist_jalr        = hist_cls_q.jalr;
  assign o_hist_branch      = hist_cls_q.branch;
  assign o_hist_rs1_ra      = hist_cls_q.rs1_ra;
  assign o_hist_jump_branch = hist_jb_q;
  assign o_hist_flush       = hist_flush_q;
  assign o_redirect         = redirect_q;
  assign o_redirect_addr    = redirect_addr_q;
  assign o_full             = fifo_full;
  assign o_err              = err_q;
  assign o_hits             = hits_q;
  assign o_misses           = misses_q;

endmodule

// File: tb/tb_riscv_next_resolve_tracker.sv
// Self-checking bench: directed vector table, reset sequence, then random traffic vs a queue model.
module tb_riscv_next_resolve_tracker;

  localparam int unsigned AW    = 64;
  localparam int unsigned DEPTH = 4;
  localparam int unsigned CW    = 3;
  localparam int          CMAX  = (1 << CW) - 1;

  logic clk = 1'b0;
  logic nreset, enable, i_stall, i_if_fire, i_pred_taken, i_ex_valid;
  logic i_ex_jal, i_ex_jalr, i_ex_branch, i_ex_rs1_ra, i_ex_taken, i_flush;
  logic [AW-1:0] i_if_pc, i_pred_addr, i_ex_pc, i_ex_target;
  logic o_hist_valid, o_hist_jal, o_hist_jalr, o_hist_branch, o_hist_rs1_ra;
  logic o_hist_jump_branch, o_hist_flush, o_redirect, o_full, o_err;
  logic [AW-1:0] o_hist_pc, o_hist_jump_addr, o_redirect_addr;
  logic [CW-1:0] o_hits, o_misses;

  int n_chk = 0;
  int n_pass = 0;

  riscv_next_resolve_tracker #(
    .ADDR_WIDTH (AW),
    .DEPTH      (DEPTH),
    .CNT_WIDTH  (CW)
  ) dut (
    .clk                (clk),
    .nreset             (nreset),
    .enable             (enable),
    .i_stall            (i_stall),
    .i_if_fire          (i_if_fire),
    .i_if_pc            (i_if_pc),
    .i_pred_taken       (i_pred_taken),
    .i_pred_addr        (i_pred_addr),
    .i_ex_valid         (i_ex_valid),
    .i_ex_pc            (i_ex_pc),
    .i_ex_jal           (i_ex_jal),
    .i_ex_jalr          (i_ex_jalr),
    .i_ex_branch        (i_ex_branch),
    .i_ex_rs1_ra        (i_ex_rs1_ra),
    .i_ex_taken         (i_ex_taken),
    .i_ex_target        (i_ex_target),
    .i_flush            (i_flush),
    .o_hist_valid       (o_hist_valid),
    .o_hist_pc          (o_hist_pc),
    .o_hist_jump_addr   (o_hist_jump_addr),
    .o_hist_jal         (o_hist_jal),
    .o_hist_jalr        (o_hist_jalr),
    .o_hist_branch      (o_hist_branch),
    .o_hist_rs1_ra      (o_hist_rs1_ra),
    .o_hist_jump_branch (o_hist_jump_branch),
    .o_hist_flush       (o_hist_flush),
    .o_redirect         (o_redirect),
    .o_redirect_addr    (o_redirect_addr),
    .o_full             (o_full),
    .o_err              (o_err),
    .o_hits             (o_hits),
    .o_misses           (o_misses)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_chk++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic st, input logic fire, input logic [63:0] pc, input logic pt,
                       input logic [63:0] pa, input logic exv, input logic [63:0] expc,
                       input logic [3:0] cls, input logic tk, input logic [63:0] tgt,
                       input logic fl);
    i_stall = st; i_if_fire = fire; i_if_pc = pc; i_pred_taken = pt; i_pred_addr = pa;
    i_ex_valid = exv; i_ex_pc = expc; {i_ex_jal, i_ex_jalr, i_ex_branch, i_ex_rs1_ra} = cls;
    i_ex_taken = tk; i_ex_target = tgt; i_flush = fl;
  endtask

  task automatic idle();
    drive(1'b0, 1'b0, '0, 1'b0, '0, 1'b0, '0, 4'b0, 1'b0, '0, 1'b0);
  endtask

  // cls = {jal, jalr, branch, rs1_ra}
  typedef struct {
    logic st, fire; logic [63:0] pc; logic pt; logic [63:0] pa;
    logic exv; logic [63:0] expc; logic [3:0] cls; logic tk; logic [63:0] tgt; logic fl;
    logic hv, rd; logic [63:0] ra; logic hf, jb, full, err; int hits, misses;
  } vec_t;

  typedef struct {
    logic [63:0] pc; logic pt; logic [63:0] pa;
  } ent_t;

  // Reference model state
  ent_t q[$];
  logic m_hv, m_rd, m_hf, m_jb, m_err;
  logic [63:0] m_ra, m_hpc, m_ja;
  logic [3:0] m_cls;
  int m_hits, m_misses;

  task automatic model_reset();
    q.delete();
    m_hv = 0; m_rd = 0; m_hf = 0; m_jb = 0; m_err = 0;
    m_ra = '0; m_hpc = '0; m_ja = '0; m_cls = '0; m_hits = 0; m_misses = 0;
  endtask

  task automatic model_step();
    logic match, ept, mis;
    logic [63:0] epa;
    mis = 1'b0;
    m_hv = 1'b0;
    m_rd = 1'b0;
    if (!enable || i_stall) return;
    if (i_ex_valid) begin
      match = (q.size() > 0) && (q[0].pc == i_ex_pc);
      ept = match ? q[0].pt : 1'b0;
      epa = match ? q[0].pa : i_ex_pc + 64'd4;
      if (!match) m_err = 1'b1;
      if (q.size() > 0) void'(q.pop_front());
      mis = (i_ex_taken != ept) || (i_ex_taken && (i_ex_target != epa));
      m_hv = 1'b1; m_rd = mis && !i_flush;
      m_ra = i_ex_taken ? i_ex_target : i_ex_pc + 64'd4;
      m_hf = i_flush; m_jb = i_ex_taken; m_hpc = i_ex_pc; m_ja = i_ex_target;
      m_cls = {i_ex_jal, i_ex_jalr, i_ex_branch, i_ex_rs1_ra};
      if ((i_ex_jal || i_ex_jalr || i_ex_branch) && !i_flush) begin
        if (mis) m_misses = (m_misses < CMAX) ? m_misses + 1 : CMAX;
        else     m_hits   = (m_hits < CMAX) ? m_hits + 1 : CMAX;
      end
    end
    if (i_if_fire && !i_flush) begin
      if (q.size() < DEPTH) q.push_back('{pc: i_if_pc, pt: i_pred_taken, pa: i_pred_addr});
      else m_err = 1'b1;
    end
    if (i_flush || mis) q.delete();
  endtask

  vec_t vt[16];

  initial begin
    nreset = 1'b0; enable = 1'b1; idle();
    //        st fire pc     pt pa      exv expc    cls     tk tgt     fl  hv rd ra     hf jb fu er h  m
    vt[0]  = '{0, 1, 'h100, 1, 'h200, 0, 0,      4'b0000, 0, 0,      0,  0, 0, 0,     0, 0, 0, 0, 0, 0};
    vt[1]  = '{0, 0, 0,     0, 0,     1, 'h100, 4'b0010, 1, 'h200,  0,  1, 0, 0,     0, 1, 0, 0, 1, 0};
    vt[2]  = '{0, 1, 'h104, 0, 0,     0, 0,      4'b0000, 0, 0,      0,  0, 0, 0,     0, 0, 0, 0, 1, 0};
    vt[3]  = '{0, 0, 0,     0, 0,     1, 'h104, 4'b0010, 1, 'h300,  0,  1, 1, 'h300, 0, 1, 0, 0, 1, 1};
    vt[4]  = '{0, 1, 'h10,  0, 0,     0, 0,      4'b0000, 0, 0,      0,  0, 0, 0,     0, 0, 0, 0, 1, 1};
    vt[5]  = '{0, 1, 'h14,  0, 0,     0, 0,      4'b0000, 0, 0,      0,  0, 0, 0,     0, 0, 0, 0, 1, 1};
    vt[6]  = '{0, 1, 'h18,  0, 0,     0, 0,      4'b0000, 0, 0,      0,  0, 0, 0,     0, 0, 0, 0, 1, 1};
    vt[7]  = '{0, 1, 'h1c,  0, 0,     0, 0,      4'b0000, 0, 0,      0,  0, 0, 0,     0, 0, 1, 0, 1, 1};
    vt[8]  = '{0, 1, 'h20,  0, 0,     0, 0,      4'b0000, 0, 0,      0,  0, 0, 0,     0, 0, 1, 1, 1, 1};
    vt[9]  = '{0, 1, 'h20,  0, 0,     1, 'h10,  4'b0000, 0, 0,      0,  1, 0, 0,     0, 0, 1, 1, 1, 1};
    vt[10] = '{0, 0, 0,     0, 0,     1, 'h14,  4'b0101, 1, 'h500,  1,  1, 0, 0,     1, 1, 0, 1, 1, 1};
    vt[11] = '{0, 0, 0,     0, 0,     1, 'h40,  4'b0000, 0, 0,      0,  1, 0, 0,     0, 0, 0, 1, 1, 1};
    vt[12] = '{1, 1, 'h30,  0, 0,     1, 'h30,  4'b0010, 1, 'h99,   0,  0, 0, 0,     0, 0, 0, 1, 1, 1};
    vt[13] = '{0, 1, 'h60,  0, 0,     0, 0,      4'b0000, 0, 0,      0,  0, 0, 0,     0, 0, 0, 1, 1, 1};
    vt[14] = '{0, 0, 0,     0, 0,     1, 'h64,  4'b1000, 1, 'h80,   0,  1, 1, 'h80,  0, 1, 0, 1, 1, 2};
    vt[15] = '{0, 0, 0,     0, 0,     1, 'h200, 4'b0010, 0, 0,      0,  1, 0, 0,     0, 0, 0, 1, 2, 2};

    #12;
    chk("reset_hist_valid", o_hist_valid, 0);
    chk("reset_full", o_full, 0);
    chk("reset_err", o_err, 0);
    chk("reset_hits", o_hits, 0);
    @(negedge clk);
    nreset = 1'b1;

    for (int i = 0; i < 16; i++) begin
      drive(vt[i].st, vt[i].fire, vt[i].pc, vt[i].pt, vt[i].pa, vt[i].exv, vt[i].expc,
            vt[i].cls, vt[i].tk, vt[i].tgt, vt[i].fl);
      step();
      chk($sformatf("v%0d_hist_valid", i), o_hist_valid, vt[i].hv);
      chk($sformatf("v%0d_redirect", i), o_redirect, vt[i].rd);
      if (vt[i].rd) chk($sformatf("v%0d_redirect_addr", i), o_redirect_addr, vt[i].ra);
      if (vt[i].hv) begin
        chk($sformatf("v%0d_hist_flush", i), o_hist_flush, vt[i].hf);
        chk($sformatf("v%0d_jump_branch", i), o_hist_jump_branch, vt[i].jb);
        chk($sformatf("v%0d_hist_pc", i), o_hist_pc, vt[i].expc);
      end
      chk($sformatf("v%0d_full", i), o_full, vt[i].full);
      chk($sformatf("v%0d_err", i), o_err, vt[i].err);
      chk($sformatf("v%0d_hits", i), 64'(o_hits), 64'(vt[i].hits));
      chk($sformatf("v%0d_misses", i), 64'(o_misses), 64'(vt[i].misses));
    end

    // Reset in the middle of a stall with three entries queued
    for (int i = 0; i < 3; i++) begin
      drive(1'b0, 1'b1, 64'h700 + 64'(4 * i), 1'b0, '0, 1'b0, '0, 4'b0, 1'b0, '0, 1'b0);
      step();
    end
    drive(1'b1, 1'b1, 64'h800, 1'b0, '0, 1'b0, '0, 4'b0, 1'b0, '0, 1'b0);
    step();
    #2 nreset = 1'b0;
    #1;
    chk("rst_err", o_err, 0);
    chk("rst_hits", o_hits, 0);
    chk("rst_misses", o_misses, 0);
    chk("rst_hist_pc", o_hist_pc, 0);
    chk("rst_redirect_addr", o_redirect_addr, 0);
    #1 nreset = 1'b1;
    drive(1'b0, 1'b1, 64'h900, 1'b1, 64'h940, 1'b0, '0, 4'b0, 1'b0, '0, 1'b0);
    step();
    chk("rst_push_full", o_full, 0);
    drive(1'b0, 1'b0, '0, 1'b0, '0, 1'b1, 64'h900, 4'b0010, 1'b1, 64'h940, 1'b0);
    step();
    chk("rst_pop_valid", o_hist_valid, 1);
    chk("rst_pop_redirect", o_redirect, 0);
    chk("rst_pop_hits", o_hits, 1);
    chk("rst_pop_err", o_err, 0);
    chk("rst_pop_pc", o_hist_pc, 64'h900);
    drive(1'b0, 1'b0, '0, 1'b0, '0, 1'b1, 64'h40, 4'b0000, 1'b0, '0, 1'b0);
    step();
    chk("empty_pop_err", o_err, 1);
    chk("empty_pop_jb", o_hist_jump_branch, 0);
    chk("empty_pop_redirect", o_redirect, 0);

    // Random traffic against the queue model
    idle();
    nreset = 1'b0;
    #3 nreset = 1'b1;
    model_reset();
    for (int c = 0; c < 3000; c++) begin
      logic [63:0] rpc, rtgt;
      logic        rtk;
      @(negedge clk);
      enable    = ($urandom_range(0, 9) != 0);
      i_stall   = ($urandom_range(0, 9) == 0);
      i_flush   = ($urandom_range(0, 24) == 0);
      i_if_fire = $urandom_range(0, 1);
      i_if_pc   = 64'($urandom_range(0, 15)) << 2;
      i_pred_taken = $urandom_range(0, 1);
      i_pred_addr  = 64'($urandom_range(0, 3)) << 6;
      i_ex_valid   = ($urandom_range(0, 2) == 0);
      rpc  = 64'($urandom_range(0, 15)) << 2;
      rtk  = $urandom_range(0, 1);
      rtgt = 64'($urandom_range(0, 3)) << 6;
      if (q.size() > 0 && $urandom_range(0, 7) != 0) begin
        rpc = q[0].pc;
        if ($urandom_range(0, 4) != 0) begin
          rtk  = q[0].pt;
          rtgt = q[0].pt ? q[0].pa : rtgt;
        end
      end
      i_ex_pc = rpc; i_ex_taken = rtk; i_ex_target = rtgt;
      {i_ex_jal, i_ex_jalr, i_ex_branch, i_ex_rs1_ra} = 4'($urandom_range(0, 15));
      model_step();
      step();
      chk("rnd_hist_valid", o_hist_valid, m_hv);
      chk("rnd_redirect", o_redirect, m_rd);
      if (m_rd) chk("rnd_redirect_addr", o_redirect_addr, m_ra);
      if (m_hv) begin
        chk("rnd_hist_pc", o_hist_pc, m_hpc);
        chk("rnd_hist_addr", o_hist_jump_addr, m_ja);
        chk("rnd_hist_cls", {o_hist_jal, o_hist_jalr, o_hist_branch, o_hist_rs1_ra}, m_cls);
        chk("rnd_hist_jb", o_hist_jump_branch, m_jb);
        chk("rnd_hist_flush", o_hist_flush, m_hf);
      end
      chk("rnd_full", o_full, (q.size() == DEPTH));
      chk("rnd_err", o_err, m_err);
      chk("rnd_hits", 64'(o_hits), 64'(m_hits));
      chk("rnd_misses", 64'(o_misses), 64'(m_misses));
    end

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
